ibex_csr_array: RTL and testbench

- Parametrised bank of NumRegs CSRs of Width bits.
- Supports CSRRW/CSRRS/CSRRC-style write ops, WARL write masking, per-register lock-until-reset and optional inverted shadow copies with read and sticky integrity errors.
- Sits between the CSR decode in ibex_cs_registers and any group of same-shaped security-relevant CSRs (e.g. PMP address, config banks).
- Replaces multiple single-register instances.

---
 rtl/ibex_csr_array.sv | 215 +++++++++++++++++++++
 tb/tb_ibex_csr_array.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_csr_array.sv
// Bank of WARL CSRs with write/set/clear ops, per-register lock and inverted shadow integrity check.
// Define IBEX_CSR_STAGED_WRITE_EN to require two identical writes before a data write commits.
module ibex_csr_array #(
  parameter int unsigned      Width      = 32,
  parameter int unsigned      NumRegs    = 4,
  parameter bit               ShadowCopy = 1'b1,
  parameter logic [Width-1:0] ResetValue = '0,
  parameter logic [Width-1:0] WriteMask  = '1,
  localparam int unsigned     AddrW      = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [AddrW-1:0]   wr_addr_i,
  input  logic [1:0]         wr_op_i,
  input  logic [Width-1:0]   wr_data_i,
  input  logic [AddrW-1:0]   rd_addr_i,
  output logic [Width-1:0]   rd_data_o,
  output logic               rd_error_o,
  output logic               wr_ignored_o,
  output logic               err_sticky_o,
  output logic [NumRegs-1:0] lock_o,
  output logic               stage_pending_o,
  output logic               stage_err_o
);

  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpSet   = 2'b01;
  localparam logic [1:0] OpClear = 2'b10;
  localparam logic [1:0] OpLock  = 2'b11;

  logic [NumRegs-1:0][Width-1:0] regs_q;
  logic [NumRegs-1:0][Width-1:0] shadow_q;
  logic [NumRegs-1:0]            lock_q;
  logic [NumRegs-1:0]            mismatch;
  logic [Width-1:0]              cur_val;
  logic [Width-1:0]              new_val;
  logic [Width-1:0]              final_val;
  logic                          wr_in_range;
  logic                          wr_locked;
  logic                          is_lock_op;
  logic                          wr_valid;
  logic                          wr_drop;
  logic                          commit_data;
  logic                          wr_ignored_q;
  logic                          err_sticky_q;

  // A power-of-two bank decodes every address, so only partial banks need a range check.
  if (NumRegs == 2 ** AddrW) begin : g_full_range
    assign wr_in_range = 1'b1;
  end else begin : g_part_range
    assign wr_in_range = (32'(wr_addr_i) < NumRegs);
  end

  always_comb begin
    cur_val   = '0;
    wr_locked = 1'b0;
    for (int i = 0; i < NumRegs; i++) begin
      if (wr_addr_i == AddrW'(i)) begin
        cur_val   = regs_q[i];
        wr_locked = lock_q[i];
      end
    end
  end

  always_comb begin
    case (wr_op_i)
      OpWrite: new_val = wr_data_i;
      OpSet:   new_val = cur_val | wr_data_i;
      OpClear: new_val = cur_val & ~wr_data_i;
      default: new_val = cur_val;
    endcase
  end

  assign final_val  = (new_val & WriteMask) | (cur_val & ~WriteMask);
  assign is_lock_op = (wr_op_i == OpLock);
  assign wr_valid   = wr_en_i & wr_in_range & (is_lock_op | ~wr_locked);
  assign wr_drop    = wr_en_i & ~wr_valid;

`ifdef IBEX_CSR_STAGED_WRITE_EN
  typedef enum logic {IDLE, STAGED} stage_e;

  stage_e           state_q, state_d;
  logic [AddrW-1:0] stg_addr_q;
  logic [1:0]       stg_op_q;
  logic [Width-1:0] stg_data_q;
  logic             capture;
  logic             stage_err_d;
  logic             stage_err_q;
  logic             stg_match;

  assign stg_match = (stg_addr_q == wr_addr_i) && (stg_op_q == wr_op_i) && (stg_data_q == wr_data_i);

  // A lock bypasses confirmation and silently abandons any staged write.
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    commit_data = 1'b0;
    stage_err_d = 1'b0;
    if (wr_valid && is_lock_op) begin
      state_d = IDLE;
    end else if (wr_valid) begin
      case (state_q)
        IDLE: begin
          capture = 1'b1;
          state_d = STAGED;
        end
        default: begin
          state_d = IDLE;
          if (stg_match) begin
            commit_data = 1'b1;
          end else begin
            stage_err_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      stg_addr_q  <= '0;
      stg_op_q    <= '0;
      stg_data_q  <= '0;
      stage_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_err_q <= stage_err_d;
      if (capture) begin
        stg_addr_q <= wr_addr_i;
        stg_op_q   <= wr_op_i;
        stg_data_q <= wr_data_i;
      end
    end
  end

  assign stage_pending_o = (state_q == STAGED);
  assign stage_err_o     = stage_err_q;
`else
  assign commit_data     = wr_valid & ~is_lock_op;
  assign stage_pending_o = 1'b0;
  assign stage_err_o     = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      regs_q       <= {NumRegs{ResetValue}};
      lock_q       <= '0;
      wr_ignored_q <= 1'b0;
    end else begin
      wr_ignored_q <= wr_drop;
      for (int i = 0; i < NumRegs; i++) begin
        if (wr_addr_i == AddrW'(i)) begin
          if (commit_data) begin
            regs_q[i] <= final_val;
          end
          if (wr_valid && is_lock_op) begin
            lock_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  // The shadow holds the complement so a stuck or flipped bit in either copy is detectable.
  if (ShadowCopy) begin : g_shadow
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        shadow_q <= {NumRegs{~ResetValue}};
      end else begin
        for (int i = 0; i < NumRegs; i++) begin
          if (commit_data && (wr_addr_i == AddrW'(i))) begin
            shadow_q[i] <= ~final_val;
          end
        end
      end
    end

    always_comb begin
      mismatch = '0;
      for (int i = 0; i < NumRegs; i++) begin
        mismatch[i] = (regs_q[i] != ~shadow_q[i]);
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        err_sticky_q <= 1'b0;
      end else begin
        err_sticky_q <= err_sticky_q | (|mismatch);
      end
    end
  end else begin : g_no_shadow
    assign shadow_q     = '0;
    assign mismatch     = '0;
    assign err_sticky_q = 1'b0;
  end

  always_comb begin
    rd_data_o  = '0;
    rd_error_o = 1'b0;
    for (int i = 0; i < NumRegs; i++) begin
      if (rd_addr_i == AddrW'(i)) begin
        rd_data_o  = regs_q[i];
        rd_error_o = mismatch[i];
      end
    end
  end

  assign wr_ignored_o = wr_ignored_q;
  assign err_sticky_o = err_sticky_q;
  assign lock_o       = lock_q;

endmodule

// File: tb/tb_ibex_csr_array.sv
// Self-checking bench for ibex_csr_array: a value-level model checked every negedge plus literal pins.
// Follows the IBEX_CSR_STAGED_WRITE_EN setting of the build.
module tb_ibex_csr_array;

  localparam logic [31:0] MASK = 32'h0000_FFFF;
  localparam logic [31:0] RV   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [1:0]  wr_op;
  logic [31:0] wr_data;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_error;
  logic        wr_ignored;
  logic        err_sticky;
  logic [3:0]  lock;
  logic        stage_pending;
  logic        stage_err;

  logic        b_wr_en;
  logic [1:0]  b_wr_addr;
  logic [1:0]  b_wr_op;
  logic [31:0] b_wr_data;
  logic [1:0]  b_rd_addr;
  logic [31:0] b_rd_data;
  logic        b_rd_error;
  logic        b_wr_ignored;
  logic        b_err_sticky;
  logic [2:0]  b_lock;
  logic        b_stage_pending;
  logic        b_stage_err;

  int checks = 0;
  int fails  = 0;
  bit check_en = 1'b0;

  logic [31:0] m_reg [4];
  logic [3:0]  m_lock;
  logic [3:0]  m_corrupt = 4'b0;
  logic        m_sticky, m_ign, m_pend, m_serr;
  logic [1:0]  s_addr, s_op;
  logic [31:0] s_data;
  logic [127:0] fv;

  always #5 clk = ~clk;

  ibex_csr_array #(
    .Width(32), .NumRegs(4), .ShadowCopy(1'b1), .ResetValue(RV), .WriteMask(MASK)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_op_i(wr_op),
    .wr_data_i(wr_data), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_error_o(rd_error),
    .wr_ignored_o(wr_ignored), .err_sticky_o(err_sticky), .lock_o(lock),
    .stage_pending_o(stage_pending), .stage_err_o(stage_err)
  );

  ibex_csr_array #(
    .Width(32), .NumRegs(3), .ShadowCopy(1'b1), .ResetValue(RV), .WriteMask(MASK)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_op_i(b_wr_op),
    .wr_data_i(b_wr_data), .rd_addr_i(b_rd_addr), .rd_data_o(b_rd_data), .rd_error_o(b_rd_error),
    .wr_ignored_o(b_wr_ignored), .err_sticky_o(b_err_sticky), .lock_o(b_lock),
    .stage_pending_o(b_stage_pending), .stage_err_o(b_stage_err)
  );

  function automatic logic [31:0] applyOp(input logic [31:0] cur, input logic [1:0] op,
                                          input logic [31:0] d);
    logic [31:0] n;
    case (op)
      2'b00:   n = d;
      2'b01:   n = cur | d;
      default: n = cur & ~d;
    endcase
    return (n & MASK) | (cur & ~MASK);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs and returns 2 time units after the edge that consumed them.
  task automatic applyStimulus(input logic en, input logic [1:0] a, input logic [1:0] op,
                               input logic [31:0] d, input logic [1:0] ra);
    wr_en   = en;
    wr_addr = a;
    wr_op   = op;
    wr_data = d;
    rd_addr = ra;
    @(posedge clk);
    #2;
  endtask

  task automatic doWrite(input logic [1:0] a, input logic [1:0] op, input logic [31:0] d);
    applyStimulus(1'b1, a, op, d, a);
`ifdef IBEX_CSR_STAGED_WRITE_EN
    applyStimulus(1'b1, a, op, d, a);
`endif
    wr_en = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_reg[i] = RV;
      m_lock = 4'b0; m_sticky = 1'b0; m_ign = 1'b0; m_pend = 1'b0; m_serr = 1'b0;
    end else begin
      if (m_corrupt != 4'b0) m_sticky = 1'b1;
      m_ign  = 1'b0;
      m_serr = 1'b0;
      if (wr_en) begin
        if (wr_op == 2'b11) begin
          m_lock[wr_addr] = 1'b1;
          m_pend = 1'b0;
        end else if (m_lock[wr_addr]) begin
          m_ign = 1'b1;
        end else begin
`ifdef IBEX_CSR_STAGED_WRITE_EN
          if (!m_pend) begin
            m_pend = 1'b1; s_addr = wr_addr; s_op = wr_op; s_data = wr_data;
          end else begin
            m_pend = 1'b0;
            if (wr_addr == s_addr && wr_op == s_op && wr_data == s_data)
              m_reg[wr_addr] = applyOp(m_reg[wr_addr], wr_op, wr_data);
            else
              m_serr = 1'b1;
          end
`else
          m_reg[wr_addr] = applyOp(m_reg[wr_addr], wr_op, wr_data);
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("rd_data", rd_data, m_reg[rd_addr]);
      checkOutput("rd_error", 32'(rd_error), 32'(m_corrupt[rd_addr]));
      checkOutput("lock", 32'(lock), 32'(m_lock));
      checkOutput("wr_ignored", 32'(wr_ignored), 32'(m_ign));
      checkOutput("err_sticky", 32'(err_sticky), 32'(m_sticky));
      checkOutput("stage_pending", 32'(stage_pending), 32'(m_pend));
      checkOutput("stage_err", 32'(stage_err), 32'(m_serr));
    end
  end

  initial begin
    wr_en = 1'b0; wr_addr = 2'd0; wr_op = 2'd0; wr_data = '0; rd_addr = 2'd0;
    b_wr_en = 1'b0; b_wr_addr = 2'd0; b_wr_op = 2'd0; b_wr_data = '0; b_rd_addr = 2'd0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    check_en = 1'b1;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'd0, 2'd0, 32'h0, 2'(i));
      checkOutput("reset_rd_data", rd_data, 32'h0);
      checkOutput("reset_rd_error", 32'(rd_error), 32'h0);
    end
    checkOutput("reset_lock", 32'(lock), 32'h0);
    checkOutput("reset_sticky", 32'(err_sticky), 32'h0);

    doWrite(2'd1, 2'b00, 32'hDEAD_BEEF);
    checkOutput("write_masked", rd_data, 32'h0000_BEEF);
    doWrite(2'd1, 2'b01, 32'h0000_0001);
    checkOutput("set_bit0", rd_data, 32'h0000_BEEF);
    doWrite(2'd1, 2'b10, 32'h0000_00FF);
    checkOutput("clear_low_byte", rd_data, 32'h0000_BE00);

    applyStimulus(1'b1, 2'd2, 2'b11, 32'hFFFF_FFFF, 2'd2);
    checkOutput("lock_set", 32'(lock), 32'h4);
    applyStimulus(1'b1, 2'd2, 2'b00, 32'h0000_1234, 2'd2);
    checkOutput("locked_write_ignored", 32'(wr_ignored), 32'h1);
    checkOutput("locked_reg_unchanged", rd_data, 32'h0);
    applyStimulus(1'b0, 2'd0, 2'd0, 32'h0, 2'd2);
    checkOutput("ignored_pulse_ends", 32'(wr_ignored), 32'h0);
    applyStimulus(1'b1, 2'd2, 2'b11, 32'h0, 2'd2);
    checkOutput("relock_no_pulse", 32'(wr_ignored), 32'h0);
    applyStimulus(1'b0, 2'd0, 2'd0, 32'h0, 2'd2);
    rst = 1'b1;
    #1;
    checkOutput("reset_clears_lock", 32'(lock), 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    b_wr_en = 1'b1; b_wr_addr = 2'd3; b_wr_op = 2'b00; b_wr_data = 32'h0000_5555; b_rd_addr = 2'd3;
    applyStimulus(1'b0, 2'd0, 2'd0, 32'h0, 2'd0);
    b_wr_en = 1'b0;
    checkOutput("oor_write_ignored", 32'(b_wr_ignored), 32'h1);
    checkOutput("oor_read_data", b_rd_data, 32'h0);
    checkOutput("oor_read_error", 32'(b_rd_error), 32'h0);
    applyStimulus(1'b0, 2'd0, 2'd0, 32'h0, 2'd0);
    checkOutput("oor_pulse_ends", 32'(b_wr_ignored), 32'h0);
    checkOutput("oor_no_lock", 32'(b_lock), 32'h0);

    // Flip bit 0 of idx0's shadow copy relative to the expected complement.
    for (int i = 0; i < 4; i++) fv[i*32 +: 32] = ~m_reg[i];
    fv[0] = ~fv[0];
    force dut.shadow_q = fv;
    m_corrupt = 4'b0001;
    applyStimulus(1'b0, 2'd0, 2'd0, 32'h0, 2'd0);
    checkOutput("force_rd_error", 32'(rd_error), 32'h1);
    checkOutput("force_sticky", 32'(err_sticky), 32'h1);
    applyStimulus(1'b0, 2'd0, 2'd0, 32'h0, 2'd1);
    checkOutput("force_other_idx", 32'(rd_error), 32'h0);
    release dut.shadow_q;
    applyStimulus(1'b0, 2'd0, 2'd0, 32'h0, 2'd1);
    applyStimulus(1'b0, 2'd0, 2'd0, 32'h0, 2'd1);
    checkOutput("sticky_after_release", 32'(err_sticky), 32'h1);
    rst = 1'b1;
    m_corrupt = 4'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    checkOutput("sticky_cleared", 32'(err_sticky), 32'h0);

    doWrite(2'd0, 2'b00, 32'h1234_5678);
    doWrite(2'd3, 2'b01, 32'hF0F0_F0F0);
    doWrite(2'd3, 2'b10, 32'h0000_00F0);
    doWrite(2'd1, 2'b00, 32'hFFFF_FFFF);
    doWrite(2'd1, 2'b10, 32'hFFFF_0F0F);
    doWrite(2'd2, 2'b01, 32'h0000_8001);
    applyStimulus(1'b0, 2'd0, 2'd0, 32'h0, 2'd0);
    checkOutput("tbl_idx0", rd_data, 32'h0000_5678);
    applyStimulus(1'b0, 2'd0, 2'd0, 32'h0, 2'd1);
    checkOutput("tbl_idx1", rd_data, 32'h0000_F0F0);
    applyStimulus(1'b0, 2'd0, 2'd0, 32'h0, 2'd2);
    checkOutput("tbl_idx2", rd_data, 32'h0000_8001);
    applyStimulus(1'b0, 2'd0, 2'd0, 32'h0, 2'd3);
    checkOutput("tbl_idx3", rd_data, 32'h0000_F000);

`ifdef IBEX_CSR_STAGED_WRITE_EN
    applyStimulus(1'b1, 2'd0, 2'b00, 32'h0000_00AA, 2'd0);
    checkOutput("stage_first_pending", 32'(stage_pending), 32'h1);
    checkOutput("stage_first_no_commit", rd_data, 32'h0000_5678);
    applyStimulus(1'b1, 2'd0, 2'b00, 32'h0000_00AA, 2'd0);
    checkOutput("stage_confirm_commit", rd_data, 32'h0000_00AA);
    checkOutput("stage_confirm_idle", 32'(stage_pending), 32'h0);
    applyStimulus(1'b1, 2'd0, 2'b00, 32'h0000_0011, 2'd0);
    checkOutput("stage_second_pending", 32'(stage_pending), 32'h1);
    applyStimulus(1'b1, 2'd0, 2'b00, 32'h0000_0022, 2'd0);
    checkOutput("stage_err_pulse", 32'(stage_err), 32'h1);
    checkOutput("stage_err_keeps_value", rd_data, 32'h0000_00AA);
    checkOutput("stage_err_idle", 32'(stage_pending), 32'h0);
    applyStimulus(1'b0, 2'd0, 2'd0, 32'h0, 2'd0);
    checkOutput("stage_err_pulse_ends", 32'(stage_err), 32'h0);
    applyStimulus(1'b1, 2'd0, 2'b00, 32'h0000_0033, 2'd0);
    applyStimulus(1'b1, 2'd0, 2'b11, 32'h0, 2'd0);
    checkOutput("lock_aborts_stage", 32'(stage_pending), 32'h0);
    checkOutput("lock_abort_no_err", 32'(stage_err), 32'h0);
    checkOutput("lock_abort_lock", 32'(lock), 32'h1);
    checkOutput("lock_abort_value", rd_data, 32'h0000_00AA);
`else
    applyStimulus(1'b1, 2'd0, 2'b00, 32'h0000_00AA, 2'd0);
    checkOutput("direct_commit", rd_data, 32'h0000_00AA);
    checkOutput("no_stage_pending", 32'(stage_pending), 32'h0);
`endif

    applyStimulus(1'b0, 2'd0, 2'd0, 32'h0, 2'd0);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
